// File: rtl/decrypt_pipe_shift_if.sv
// Bus bundle for decrypt_pipe_shift: byte stream in, key/schedule controls, plaintext stream out.
// master drives the ciphertext side; slave is the decrypt pipeline.
interface decrypt_pipe_shift_if;
  logic        en;
  logic [7:0]  din;
  logic [7:0]  k1;
  logic [7:0]  k2;
  logic [7:0]  k3;
  logic [2:0]  rot_freq;
  logic        shift_en;
  logic        mode;
  logic        sync_clr;
  logic [7:0]  dout;
  logic        en_out;
  logic        is_alpha_out;
  logic [15:0] alpha_cnt;

  modport master (
    output en, din, k1, k2, k3, rot_freq, shift_en, mode, sync_clr,
    input  dout, en_out, is_alpha_out, alpha_cnt
  );

  modport slave (
    input  en, din, k1, k2, k3, rot_freq, shift_en, mode, sync_clr,
    output dout, en_out, is_alpha_out, alpha_cnt
  );
endinterface

// File: rtl/decrypt_pipe_shift.sv
// Two-stage Caesar decrypt pipeline with a rotating k1->k2->k3 key schedule.
// Optional DECRYPT_STATS_EN adds a saturating count of decrypted alpha bytes.
module decrypt_pipe_shift (
  input  logic                 clk,
  input  logic                 rst,
  decrypt_pipe_shift_if.slave  bus
);

  typedef enum logic [1:0] {
    KEY1 = 2'd0,
    KEY2 = 2'd1,
    KEY3 = 2'd2
  } key_state_t;

  key_state_t r_key_idx;
  key_state_t w_key_idx_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;

  logic       w_is_upper;
  logic       w_is_lower;
  logic       w_is_alpha;
  logic [7:0] w_base;
  logic [4:0] w_offset;
  logic [7:0] w_key;
  logic [4:0] w_kmod;
  logic       w_count_byte;

  logic       r_s1_valid;
  logic [7:0] r_s1_byte;
  logic [4:0] r_s1_offset;
  logic [4:0] r_s1_kmod;
  logic       r_s1_upper;
  logic       r_s1_lower;
  logic       r_s1_shift;

  logic signed [5:0] w_diff;
  logic signed [5:0] w_wrapped;
  logic              w_s1_alpha;
  logic [7:0]        w_dout;

  logic       r_en_out;
  logic [7:0] r_dout;
  logic       r_is_alpha;

  always_comb begin
    w_is_upper = (bus.din >= 8'h41) && (bus.din <= 8'h5A);
    w_is_lower = (bus.din >= 8'h61) && (bus.din <= 8'h7A);
    w_is_alpha = w_is_upper || w_is_lower;
    w_base     = w_is_lower ? 8'h61 : 8'h41;
    w_offset   = 5'(bus.din - w_base);
  end

  // A byte arriving with sync_clr is already decrypted with k1, regardless of schedule.
  always_comb begin
    w_key = bus.k1;
    if (bus.mode && !bus.sync_clr) begin
      case (r_key_idx)
        KEY2:    w_key = bus.k2;
        KEY3:    w_key = bus.k3;
        default: w_key = bus.k1;
      endcase
    end
    w_kmod = 5'(w_key % 8'd26);
  end

  always_comb begin
    w_key_idx_nxt = r_key_idx;
    w_cnt_nxt     = r_cnt;
    w_count_byte  = bus.en && bus.shift_en && bus.mode && w_is_alpha;
    if (bus.sync_clr) begin
      w_key_idx_nxt = KEY1;
      w_cnt_nxt     = 3'd0;
    end else if (w_count_byte) begin
      // >= lets a lowered rot_freq take effect on the very next alpha byte
      if (r_cnt >= bus.rot_freq) begin
        w_cnt_nxt = 3'd0;
        case (r_key_idx)
          KEY1:    w_key_idx_nxt = KEY2;
          KEY2:    w_key_idx_nxt = KEY3;
          default: w_key_idx_nxt = KEY1;
        endcase
      end else begin
        w_cnt_nxt = r_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_idx <= KEY1;
      r_cnt     <= 3'd0;
    end else begin
      r_key_idx <= w_key_idx_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_byte   <= 8'h00;
      r_s1_offset <= 5'd0;
      r_s1_kmod   <= 5'd0;
      r_s1_upper  <= 1'b0;
      r_s1_lower  <= 1'b0;
      r_s1_shift  <= 1'b0;
    end else begin
      r_s1_valid <= bus.en;
      if (bus.en) begin
        r_s1_byte   <= bus.din;
        r_s1_offset <= w_offset;
        r_s1_kmod   <= w_kmod;
        r_s1_upper  <= w_is_upper;
        r_s1_lower  <= w_is_lower;
        r_s1_shift  <= bus.shift_en;
      end
    end
  end

  // offset and kmod are both 0..25, so one +26 correction always lands back in range
  always_comb begin
    w_diff     = $signed({1'b0, r_s1_offset}) - $signed({1'b0, r_s1_kmod});
    w_wrapped  = w_diff[5] ? (w_diff + 6'sd26) : w_diff;
    w_s1_alpha = (r_s1_upper || r_s1_lower) && r_s1_shift;
    w_dout     = r_s1_byte;
    if (w_s1_alpha) begin
      w_dout = (r_s1_upper ? 8'h41 : 8'h61) + {3'b000, w_wrapped[4:0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en_out   <= 1'b0;
      r_dout     <= 8'h00;
      r_is_alpha <= 1'b0;
    end else begin
      r_en_out <= r_s1_valid;
      if (r_s1_valid) begin
        r_dout     <= w_dout;
        r_is_alpha <= w_s1_alpha;
      end
    end
  end

  assign bus.dout         = r_dout;
  assign bus.en_out       = r_en_out;
  assign bus.is_alpha_out = r_is_alpha;

`ifdef DECRYPT_STATS_EN
  logic [15:0] r_alpha_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alpha_cnt <= 16'h0000;
    end else if (bus.sync_clr) begin
      r_alpha_cnt <= 16'h0000;
    end else if (r_en_out && r_is_alpha && (r_alpha_cnt != 16'hFFFF)) begin
      r_alpha_cnt <= r_alpha_cnt + 16'h0001;
    end
  end

  assign bus.alpha_cnt = r_alpha_cnt;
`else
  assign bus.alpha_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_decrypt_pipe_shift.sv
// Self-checking bench for decrypt_pipe_shift: vector table plus scoreboard queue,
// hand-written reset-mid-stream sequence and a random single-key sweep.
module tb_decrypt_pipe_shift;

`ifdef DECRYPT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int         gap;
    logic [7:0] din;
    logic [7:0] k1;
    logic [7:0] k2;
    logic [7:0] k3;
    logic [2:0] rot;
    logic       se;
    logic       mode;
    logic       sc;
    logic [7:0] exp_dout;
    logic       exp_alpha;
  } vec_t;

  typedef struct {
    logic [7:0] dout;
    logic       alpha;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   tbAlpha = 0;
  exp_t sbq[$];
  vec_t vecs[$];

  decrypt_pipe_shift_if bus ();

  decrypt_pipe_shift dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input int gap, input logic [7:0] din, input logic [7:0] k1,
                              input logic [7:0] k2, input logic [7:0] k3, input logic [2:0] rot,
                              input logic se, input logic mode, input logic sc,
                              input logic [7:0] ed, input logic ea);
    vec_t v;
    v.gap = gap; v.din = din; v.k1 = k1; v.k2 = k2; v.k3 = k3; v.rot = rot;
    v.se = se; v.mode = mode; v.sc = sc; v.exp_dout = ed; v.exp_alpha = ea;
    return v;
  endfunction

  // Reference decrypt with a single key; returns {alpha, plaintext}.
  function automatic logic [8:0] model(input logic [7:0] c, input logic [7:0] k);
    int ci, kk;
    ci = int'(c);
    kk = int'(k) % 26;
    if (ci >= 65 && ci <= 90)  return {1'b1, 8'(65 + (ci - 65 - kk + 26) % 26)};
    if (ci >= 97 && ci <= 122) return {1'b1, 8'(97 + (ci - 97 - kk + 26) % 26)};
    return {1'b0, c};
  endfunction

  task automatic idle();
    bus.en  = 1'b0;
    bus.din = 8'h44;
    bus.sync_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    repeat (v.gap) idle();
    bus.din = v.din; bus.k1 = v.k1; bus.k2 = v.k2; bus.k3 = v.k3;
    bus.rot_freq = v.rot; bus.shift_en = v.se; bus.mode = v.mode; bus.sync_clr = v.sc;
    bus.en = 1'b1;
    if (v.sc) begin
      tbAlpha = 0;
      foreach (sbq[j]) if (sbq[j].alpha && sbq[j].cyc >= cyc - 1) tbAlpha++;
    end
    if (v.exp_alpha) tbAlpha++;
    e.dout = v.exp_dout; e.alpha = v.exp_alpha; e.cyc = cyc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    bus.sync_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) idle();
    checkOutput("drain", sbq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst && bus.en_out) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput("dout", bus.dout, e.dout);
        checkOutput("is_alpha_out", bus.is_alpha_out, e.alpha);
        checkOutput("latency", cyc, e.cyc + 2);
      end
    end
  end

  initial begin
    #200000;
    checkOutput("timeout", 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vec_t v;
    logic [8:0] m;

    bus.en = 1'b0; bus.din = 8'h00; bus.k1 = 8'd3; bus.k2 = 8'd0; bus.k3 = 8'd0;
    bus.rot_freq = 3'd0; bus.shift_en = 1'b1; bus.mode = 1'b0; bus.sync_clr = 1'b0;

    // single key, case wrap, key mod 26, non-alpha, bypass
    vecs.push_back(mk(0, 8'h44, 8'd3,  0, 0, 0, 1, 0, 0, 8'h41, 1));
    vecs.push_back(mk(0, 8'h61, 8'd3,  0, 0, 0, 1, 0, 0, 8'h78, 1));
    vecs.push_back(mk(0, 8'h5A, 8'd3,  0, 0, 0, 1, 0, 0, 8'h57, 1));
    vecs.push_back(mk(0, 8'h45, 8'd30, 0, 0, 0, 1, 0, 0, 8'h41, 1));
    vecs.push_back(mk(1, 8'h35, 8'd3,  0, 0, 0, 1, 0, 0, 8'h35, 0));
    vecs.push_back(mk(0, 8'h44, 8'd3,  0, 0, 0, 0, 0, 0, 8'h44, 0));
    // rotation every 2 alpha bytes, non-alpha inserted while cnt=1
    vecs.push_back(mk(0, 8'h42, 1, 2, 3, 1, 1, 1, 0, 8'h41, 1));
    vecs.push_back(mk(0, 8'h42, 1, 2, 3, 1, 1, 1, 0, 8'h41, 1));
    vecs.push_back(mk(0, 8'h42, 1, 2, 3, 1, 1, 1, 0, 8'h5A, 1));
    vecs.push_back(mk(0, 8'h35, 1, 2, 3, 1, 1, 1, 0, 8'h35, 0));
    vecs.push_back(mk(0, 8'h42, 1, 2, 3, 1, 1, 1, 0, 8'h5A, 1));
    vecs.push_back(mk(0, 8'h42, 1, 2, 3, 1, 1, 1, 0, 8'h59, 1));
    vecs.push_back(mk(0, 8'h42, 1, 2, 3, 1, 1, 1, 0, 8'h59, 1));
    vecs.push_back(mk(0, 8'h42, 1, 2, 3, 1, 1, 1, 0, 8'h41, 1));
    // sync_clr while key_idx=2
    vecs.push_back(mk(0, 8'h44, 3, 5, 7, 0, 1, 1, 0, 8'h41, 1));
    vecs.push_back(mk(0, 8'h44, 3, 5, 7, 0, 1, 1, 0, 8'h59, 1));
    vecs.push_back(mk(0, 8'h44, 3, 5, 7, 0, 1, 1, 1, 8'h41, 1));
    vecs.push_back(mk(0, 8'h44, 3, 5, 7, 0, 1, 1, 0, 8'h41, 1));
    // restart, idle gaps must not count, then lower rot_freq mid-stream
    vecs.push_back(mk(0, 8'h44, 3, 5, 7, 7, 1, 1, 1, 8'h41, 1));
    vecs.push_back(mk(2, 8'h44, 3, 5, 7, 7, 1, 1, 0, 8'h41, 1));
    vecs.push_back(mk(0, 8'h44, 3, 5, 7, 7, 1, 1, 0, 8'h41, 1));
    vecs.push_back(mk(1, 8'h44, 3, 5, 7, 1, 1, 1, 0, 8'h41, 1));
    vecs.push_back(mk(0, 8'h44, 3, 5, 7, 1, 1, 1, 0, 8'h59, 1));
    vecs.push_back(mk(0, 8'h64, 3, 5, 7, 1, 1, 1, 0, 8'h79, 1));

    #2 rst = 1'b0;
    #1;
    checkOutput("reset_en_out", bus.en_out, 0);
    checkOutput("reset_dout", bus.dout, 0);
    checkOutput("reset_is_alpha", bus.is_alpha_out, 0);
    checkOutput("reset_alpha_cnt", bus.alpha_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);
    drain();
    idle(); idle();
    checkOutput("alpha_cnt_table", bus.alpha_cnt, STATS ? tbAlpha : 0);

    for (int i = 0; i < 16; i++) begin
      v = mk(0, 8'($urandom_range(32, 126)), 8'($urandom_range(0, 255)), 0, 0, 0, 1, 0, 0, 0, 0);
      m = model(v.din, v.k1);
      v.exp_alpha = m[8];
      v.exp_dout  = m[7:0];
      applyStimulus(v);
    end
    drain();

    // reset with two alpha bytes in flight and the schedule advanced
    bus.k1 = 8'd3; bus.k2 = 8'd5; bus.k3 = 8'd7; bus.rot_freq = 3'd0;
    bus.mode = 1'b1; bus.shift_en = 1'b1; bus.din = 8'h44; bus.en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.en = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("midreset_en_out", bus.en_out, 0);
    checkOutput("midreset_dout", bus.dout, 0);
    checkOutput("midreset_alpha_cnt", bus.alpha_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tbAlpha = 0;
    @(posedge clk); #1;
    applyStimulus(mk(0, 8'h44, 3, 5, 7, 0, 1, 1, 0, 8'h41, 1));
    drain();
    idle(); idle();
    checkOutput("alpha_cnt_after_reset", bus.alpha_cnt, STATS ? 1 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decrypt_pipe_shift.md
# decrypt_pipe_shift

Two-stage decryption shift pipeline: the receive-side inverse of the encrypt pipeline's data-compare/shift path. It classifies each incoming byte as upper/lower-case alpha and subtracts the currently active key modulo 26 within the same case. Non-alpha bytes pass unchanged. The active key rotates k1→k2→k3→k1 after a programmable number of alpha characters, so the block reproduces the encrypter's key schedule in reverse.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  input byte valid
- din  in  8  ciphertext byte (ASCII)
- k1, k2, k3  in  8 each  keys; reduced mod 26 internally
- rot_freq  in  3  key advances after rot_freq+1 alpha chars
- shift_en  in  1  1 = decrypt alpha bytes; 0 = pass all bytes unchanged, rotation frozen
- mode  in  1  1 = rotating key schedule; 0 = k1 only, rotation frozen
- sync_clr  in  1  synchronous restart of key schedule
- dout  out  8  plaintext byte
- en_out  out  1  dout valid
- is_alpha_out  out  1  dout byte was alpha and was shifted
- alpha_cnt  out  16  alpha bytes decrypted (see Configuration)

## Operation
- Classification: upper = 0x41..0x5A, lower = 0x61..0x7A; base = 0x41 or 0x61.
- Stage 1, registered on en=1:
  - offset = din − base (0..25)
  - kmod = selected key % 26
  - case flags and the raw byte are also registered.
- Stage 2: r = offset − kmod; if r < 0 then r += 26; dout = base + r.
  - Non-alpha, or shift_en=0: dout = din.
  - Arithmetic is done in 6-bit signed; the result is always in 0..25.
- Key selection: key_idx (0,1,2 → k1,k2,k3); k3 wraps to k1. mode=0 forces k1.
- Rotation counter cnt (3b) advances on en & shift_en & mode & alpha.
  - When cnt >= rot_freq: cnt←0 and key_idx advances. Otherwise cnt←cnt+1.
  - The byte that triggers the advance uses the pre-advance key.
  - The >= comparison ensures a mid-stream lowering of rot_freq rotates on the next alpha byte.
- sync_clr has priority over the counter. A byte accepted in the same cycle is decrypted with k1; afterwards key_idx=0 and cnt=0, and that byte is not counted.
- en=0 cycles: no state change in the rotation logic.
  - Pipeline registers still shift, so en_out deasserts two cycles later.
- Keys, rot_freq and mode are sampled at stage-1 capture. Later changes do not affect bytes already in flight.

## Timing
- Latency: a byte on din with en=1 at edge N appears on dout with en_out=1 after edge N+2.
- Throughput: one byte per cycle, no backpressure, no stalls.
- Reset (rst=0, asynchronous): dout=0x00, en_out=0, is_alpha_out=0, alpha_cnt=0, key_idx=0, cnt=0, all pipeline valids 0.
  - Reset mid-stream discards in-flight bytes; no output is produced for them.
  - After release, the first alpha byte uses k1.
- dout and is_alpha_out are held at their last value while en_out=0; only en_out qualifies them.

## Configuration
- Macro DECRYPT_STATS_EN.
- Defined: alpha_cnt increments when en_out=1 and is_alpha_out=1, saturates at 0xFFFF, and clears on reset or sync_clr.
- Undefined: counter logic is removed and alpha_cnt is tied to 0.

## Test plan
- Basic shift: k1=3, mode=0, shift_en=1, din=0x44 'D' → dout=0x41 'A', en_out=1 and is_alpha_out=1 exactly two cycles later.
- Wrap and case: k1=3, din=0x61 'a' → 0x78 'x'. din=0x5A 'Z' → 0x57 'W'. k1=30 (mod 26 = 4), din=0x45 'E' → 0x41.
- Non-alpha and bypass:
  - din=0x35 '5' → 0x35 with is_alpha_out=0 and the counter unchanged.
  - shift_en=0, din=0x44 → 0x44.
- Rotation: k1=1, k2=2, k3=3, mode=1, rot_freq=1, seven back-to-back 'B' (0x42) → A,A,Z,Z,Y,Y,A. A non-alpha byte inserted mid-stream does not advance cnt.
- sync_clr: after two alpha bytes with rot_freq=0 (key_idx=2), assert sync_clr with din='D' and k1=3 → 'A'. The next alpha byte also uses k1.
- Reset mid-stream: assert rst low while two bytes are in flight → en_out=0 and dout=0x00 immediately. After release, 'D' with k1=3 → 'A'. With DECRYPT_STATS_EN defined, alpha_cnt=0 after reset and =1 after that byte.
